// File: rtl/bchecc_pkg.sv
// BCH(t=15) over GF(2^13) encoder constants, field helpers and FSM state type.
// The generator polynomial is derived at elaboration time from the field
// primitive polynomial x^13+x^4+x^3+x+1 as the product of minimal polynomials m1*m3*...*m29.
package bchecc_pkg;

    localparam int BCH_M         = 13;
    localparam int BCH_T         = 15;
    localparam int BCH_PAR_BITS  = 195;
    localparam int BCH_PAR_BYTES = 25;

    // Low bits of the primitive polynomial (x^13 term implicit in the reduction)
    localparam logic [BCH_M-1:0] BCH_PRIM_LO = 13'h001B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_OUT  = 2'd2
    } bch_state_e;

    // GF(2^13) multiply, shift-and-add with modular reduction
    function automatic logic [BCH_M-1:0] gf_mul(input logic [BCH_M-1:0] a, input logic [BCH_M-1:0] b);
        logic [BCH_M-1:0] p;
        logic [BCH_M-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < BCH_M; i++) begin
            if (b[i]) p = p ^ x;
            x = x[BCH_M-1] ? ((x << 1) ^ BCH_PRIM_LO) : (x << 1);
        end
        return p;
    endfunction

    // Minimal polynomial of beta: product of (x + beta^(2^k)), k = 0..12.
    // Coefficients land in GF(2), so only bit 0 of each is kept.
    function automatic logic [BCH_M:0] bch_min_poly(input logic [BCH_M-1:0] beta);
        logic [BCH_M:0][BCH_M-1:0] c;
        logic [BCH_M-1:0]          root;
        logic [BCH_M:0]            m;
        c    = '0;
        c[0] = 13'd1;
        root = beta;
        for (int k = 0; k < BCH_M; k++) begin
            for (int n = BCH_M; n > 0; n--) c[n] = c[n-1] ^ gf_mul(root, c[n]);
            c[0] = gf_mul(root, c[0]);
            root = gf_mul(root, root);
        end
        m = '0;
        for (int n = 0; n <= BCH_M; n++) m[n] = c[n][0];
        return m;
    endfunction

    // Generator g(x) = lcm of minimal polynomials of alpha^1..alpha^2t
    function automatic logic [BCH_PAR_BITS:0] bch_gen_poly();
        logic [BCH_PAR_BITS:0] g;
        logic [BCH_PAR_BITS:0] acc;
        logic [BCH_M:0]        m;
        logic [BCH_M-1:0]      alpha_i;
        g       = '0;
        g[0]    = 1'b1;
        alpha_i = 13'd1;
        for (int i = 1; i < 2 * BCH_T; i++) begin
            alpha_i = gf_mul(alpha_i, 13'd2);
            if ((i % 2) == 1) begin
                m   = bch_min_poly(alpha_i);
                acc = '0;
                for (int n = 0; n <= BCH_M; n++) begin
                    if (m[n]) acc = acc ^ (g << n);
                end
                g = acc;
            end
        end
        return g;
    endfunction

    // Bit 195 is the implicit x^195 term
    localparam logic [BCH_PAR_BITS:0] BCH_GEN_POLY = bch_gen_poly();

endpackage

// File: rtl/bchecc_enc_lfsr8.sv
// Next-remainder function: eight serial BCH LFSR steps unrolled, data MSB first.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module bchecc_enc_lfsr8
    import bchecc_pkg::*;
(
    input  logic [BCH_PAR_BITS-1:0] r_i,
    input  logic [7:0]              d_i,
    output logic [BCH_PAR_BITS-1:0] r_o
);

    logic [BCH_PAR_BITS-1:0] r;
    logic                    fb;

    // Eight divide-by-g(x) steps, bit 7 of the byte first
    always_comb begin
        r  = r_i;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb = d_i[i] ^ r[BCH_PAR_BITS-1];
            r  = {r[BCH_PAR_BITS-2:0], 1'b0} ^ (fb ? BCH_GEN_POLY[BCH_PAR_BITS-1:0] : '0);
        end
        r_o = r;
    end

endmodule

// File: rtl/bchecc_encoder.sv
// Byte-serial BCH(t=15, GF(2^13)) encoder: DATA_BYTES in, 25 parity bytes out.
// Latency: first parity byte valid the cycle after the last data transfer; 1 byte/cycle each way.
// Backpressure: data_rdy_o only while encoding; par_o/par_vld_o hold while par_rdy_i is low.
// Optional macro BCHECC_ENC_PAR_INV_EN: parity bytes (incl. padding) leave inverted.
module bchecc_encoder
    import bchecc_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 512
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       data_vld_i,
    output logic       data_rdy_o,
    output logic [7:0] par_o,
    output logic       par_vld_o,
    input  logic       par_rdy_i,
    output logic       busy_o,
    output logic       done_o
);

    localparam int        PB        = BCH_PAR_BITS;
    localparam logic [9:0] LAST_DATA = 10'(DATA_BYTES - 1);
    localparam logic [4:0] LAST_PAR  = 5'(BCH_PAR_BYTES - 1);

`ifdef BCHECC_ENC_PAR_INV_EN
    // Inverted parity makes an erased (all 0xFF) page a valid codeword
    localparam logic [7:0] PAR_XOR = 8'hFF;
`else
    localparam logic [7:0] PAR_XOR = 8'h00;
`endif

    bch_state_e    state_q, state_d;
    logic [PB-1:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [9:0]    dcnt_q, dcnt_d;
    logic [4:0]    pcnt_q, pcnt_d;
    logic          done_q, done_d;

    bchecc_enc_lfsr8 u_lfsr8 (
        .r_i (lfsr_q),
        .d_i (data_i),
        .r_o (lfsr_nxt)
    );

    // State, remainder and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            dcnt_q  <= dcnt_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
        end
    end

    // Next state, handshakes and parity output; the remainder doubles as the parity shifter
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        dcnt_d     = dcnt_q;
        pcnt_d     = pcnt_q;
        done_d     = 1'b0;
        data_rdy_o = 1'b0;
        par_vld_o  = 1'b0;
        par_o      = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ENC;
                    lfsr_d  = '0;
                    dcnt_d  = '0;
                    pcnt_d  = '0;
                end
            end
            ST_ENC: begin
                data_rdy_o = 1'b1;
                if (data_vld_i) begin
                    lfsr_d = lfsr_nxt;
                    if (dcnt_q == LAST_DATA) begin
                        state_d = ST_OUT;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 10'd1;
                    end
                end
            end
            ST_OUT: begin
                par_vld_o = 1'b1;
                // Zeros shifted in below r[2:0] form the padding of the last byte
                par_o     = lfsr_q[PB-1 -: 8] ^ PAR_XOR;
                if (par_rdy_i) begin
                    lfsr_d = {lfsr_q[PB-9:0], 8'h00};
                    if (pcnt_q == LAST_PAR) begin
                        state_d = ST_IDLE;
                        pcnt_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_bchecc_encoder.sv
// Self-checking bench for bchecc_encoder: randomized sectors and handshakes
// against a polynomial long-division model plus read-side syndrome evaluation.
module tb_bchecc_encoder;

    localparam int NB    = 512;
    localparam int PB    = 195;
    localparam int PBY   = 25;
    localparam int NBITS = NB * 8 + PB;
    localparam int NQ    = 8191;

`ifdef BCHECC_ENC_PAR_INV_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] data_i;
    logic       data_vld_i;
    logic       data_rdy_o;
    logic [7:0] par_o;
    logic       par_vld_o;
    logic       par_rdy_i;
    logic       busy_o;
    logic       done_o;

    always #5 clk_i = ~clk_i;

    bchecc_encoder #(.DATA_BYTES(NB)) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .data_i     (data_i),
        .data_vld_i (data_vld_i),
        .data_rdy_o (data_rdy_o),
        .par_o      (par_o),
        .par_vld_o  (par_vld_o),
        .par_rdy_i  (par_rdy_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    int             n_chk = 0;
    int             n_err = 0;
    int             gf_exp [NQ];
    int             gf_log [NQ+1];
    logic [PB:0]    g_ref;
    logic [7:0]     msg [NB];

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp[(gf_log[a] + gf_log[b]) % NQ];
    endfunction

    // Field tables, then g(x) as the product of (x + alpha^e) over every
    // conjugate of alpha^1..alpha^30
    task automatic build_model();
        int  x;
        int  deg;
        int  e;
        int  co [PB+1];
        bit  mark [NQ];
        x = 1;
        for (int i = 0; i < NQ; i++) begin
            gf_exp[i] = x;
            gf_log[x] = i;
            x = x << 1;
            if ((x & 32'h2000) != 0) x = x ^ 32'h201B;
        end
        for (int i = 0; i < NQ; i++) mark[i] = 1'b0;
        for (int s = 1; s <= 30; s++) begin
            e = s;
            for (int k = 0; k < 13; k++) begin
                mark[e] = 1'b1;
                e = (e * 2) % NQ;
            end
        end
        for (int i = 0; i <= PB; i++) co[i] = 0;
        co[0] = 1;
        deg = 0;
        for (int r = 1; r < NQ; r++) begin
            if (mark[r] && deg < PB) begin
                for (int n = deg + 1; n > 0; n--) co[n] = co[n-1] ^ gmul(gf_exp[r], co[n]);
                co[0] = gmul(gf_exp[r], co[0]);
                deg++;
            end
        end
        for (int i = 0; i <= PB; i++) g_ref[i] = co[i][0];
    endtask

    // Remainder of m(x)*x^195 divided by g(x); array index = degree
    task automatic model_parity(output logic [PB-1:0] rem);
        bit c [NBITS];
        for (int i = 0; i < NBITS; i++) c[i] = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 8; k++) c[PB + (NB - 1 - b) * 8 + k] = msg[b][k];
        for (int d = NBITS - 1; d >= PB; d--)
            if (c[d]) for (int j = 0; j <= PB; j++) c[d - PB + j] = c[d - PB + j] ^ g_ref[j];
        for (int j = 0; j < PB; j++) rem[j] = c[j];
    endtask

    // Any of S1..S30 nonzero for the codeword message||parity
    function automatic bit syn_nonzero(input logic [PB-1:0] par);
        bit c [NBITS];
        int s;
        for (int j = 0; j < PB; j++) c[j] = par[j];
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 8; k++) c[PB + (NB - 1 - b) * 8 + k] = msg[b][k];
        for (int j = 1; j <= 30; j++) begin
            s = 0;
            for (int d = 0; d < NBITS; d++) if (c[d]) s = s ^ gf_exp[(j * d) % NQ];
            if (s != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_sector(input string tag, input int vld_pct, input int rdy_pct,
                              input bit stall_last, input bit poke_start,
                              input int abort_d, input int abort_p, input int exp_cyc,
                              output logic [199:0] gotv);
        logic [7:0]    got [PBY];
        logic [PB-1:0] rem;
        logic [199:0]  expv;
        logic [199:0]  raw;
        logic [7:0]    prev_par;
        int            idx, pidx, cyc, stall_n, unstable, busy_bad;
        bit            fin, prev_stall;
        idx = 0; pidx = 0; stall_n = 0; unstable = 0; busy_bad = 0;
        fin = 1'b0; prev_stall = 1'b0; prev_par = 8'h00;
        for (int k = 0; k < PBY; k++) got[k] = 8'h00;
        gotv = '0;
        // Start cycle also offers junk data to the idle encoder
        start_i = 1'b1; data_vld_i = 1'b1; data_i = 8'hA5; par_rdy_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 1;
        while (!fin && cyc <= 4000) begin
            if (idx == abort_d || pidx == abort_p) begin
                rst_i = 1'b1; data_vld_i = 1'b0; par_rdy_i = 1'b0; start_i = 1'b0;
                @(posedge clk_i); #1;
                chk({tag, "_abort_outs"}, 200'({data_rdy_o, par_vld_o, par_o, busy_o, done_o}), 200'(0));
                rst_i = 1'b0;
                @(posedge clk_i); #1;
                return;
            end
            data_vld_i = (idx < NB) && ($urandom_range(99) < vld_pct);
            data_i     = data_vld_i ? msg[idx] : 8'($urandom);
            par_rdy_i  = $urandom_range(99) < rdy_pct;
            if (stall_last && pidx == PBY - 1 && stall_n < 10) begin
                par_rdy_i = 1'b0;
                stall_n++;
            end
            start_i = poke_start && ((idx == 300 && data_rdy_o) || (pidx == 5 && par_vld_o) ||
                                     (pidx == PBY - 1 && par_vld_o && par_rdy_i));
            if (prev_stall && par_o !== prev_par) unstable++;
            if (done_o) fin = 1'b1;
            else if (!busy_o) busy_bad++;
            if (data_vld_i && data_rdy_o) idx++;
            if (par_vld_o && par_rdy_i) begin
                if (pidx < PBY) got[pidx] = par_o;
                pidx++;
            end
            prev_stall = par_vld_o && !par_rdy_i;
            prev_par   = par_o;
            if (!fin) begin
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        chk({tag, "_finished"}, 200'(fin), 200'(1));
        chk({tag, "_busy_at_done"}, 200'(busy_o), 200'(0));
        chk({tag, "_busy_stalls"}, 200'(busy_bad), 200'(0));
        chk({tag, "_stall_stable"}, 200'(unstable), 200'(0));
        if (exp_cyc > 0) chk({tag, "_done_latency"}, 200'(cyc), 200'(exp_cyc));
        start_i = 1'b0; data_vld_i = 1'b0; par_rdy_i = 1'b0;
        @(posedge clk_i); #1;
        chk({tag, "_done_pulse"}, 200'({done_o, busy_o}), 200'(0));
        for (int k = 0; k < PBY; k++) gotv[199 - 8 * k -: 8] = got[k];
        model_parity(rem);
        expv = {rem, 5'b0} ^ {PBY{INV}};
        chk({tag, "_parity"}, gotv, expv);
        raw = gotv ^ {PBY{INV}};
        chk({tag, "_syndromes"}, 200'(syn_nonzero(raw[199:5])), 200'(0));
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++) msg[b] = 8'($urandom);
    endtask

    initial begin
        logic [199:0] pv;
        rst_i = 1'b1; start_i = 1'b0; data_i = 8'h00; data_vld_i = 1'b0; par_rdy_i = 1'b0;
        build_model();
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_state", 200'({data_rdy_o, par_vld_o, par_o, busy_o, done_o}), 200'(0));
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int b = 0; b < NB; b++) msg[b] = 8'h00;
        run_sector("zero", 100, 100, 1'b0, 1'b0, -1, -1, NB + PBY + 1, pv);
        chk("zero_const", pv, {PBY{INV}});

        msg[NB-1] = 8'h01;
        run_sector("onebit", 100, 100, 1'b0, 1'b0, -1, -1, NB + PBY + 1, pv);
        chk("onebit_gen", pv, {g_ref[PB-1:0], 5'b0} ^ {PBY{INV}});

        fill_random(); run_sector("rnd_full", 100, 100, 1'b0, 1'b0, -1, -1, NB + PBY + 1, pv);
        fill_random(); run_sector("rnd_bp1", 60, 70, 1'b0, 1'b0, -1, -1, 0, pv);
        fill_random(); run_sector("rnd_bp2", 85, 40, 1'b1, 1'b0, -1, -1, 0, pv);
        fill_random(); run_sector("rnd_bp3", 50, 50, 1'b1, 1'b0, -1, -1, 0, pv);
        fill_random(); run_sector("rnd_poke", 80, 80, 1'b0, 1'b1, -1, -1, 0, pv);
        fill_random(); run_sector("rnd_poke2", 100, 100, 1'b0, 1'b1, -1, -1, NB + PBY + 1, pv);

        fill_random(); run_sector("abort_data", 90, 90, 1'b0, 1'b0, 300, -1, 0, pv);
        fill_random(); run_sector("after_abort_d", 75, 75, 1'b0, 1'b0, -1, -1, 0, pv);
        fill_random(); run_sector("abort_par", 90, 90, 1'b0, 1'b0, -1, 5, 0, pv);
        fill_random(); run_sector("after_abort_p", 100, 100, 1'b0, 1'b0, -1, -1, NB + PBY + 1, pv);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_sector("rnd_loop", 40 + 15 * r, 95 - 15 * r, r[0], 1'b0, -1, -1, 0, pv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bchecc_encoder.md
Name: bchecc_encoder

Overview:
- Byte-serial BCH encoder over GF(2^13), t=15 (generator degree 195) for the NFC ECC path: the write-side counterpart of the syndrome/Chien multiplier arrays on the read side.
- Consumes one sector of data bytes through a valid/ready handshake and accumulates the remainder in an 8-bit-parallel LFSR.
- Then streams the 25 parity bytes out through a second valid/ready handshake toward the NAND write datapath.

Parameters:
- DATA_BYTES, 512, bytes per sector (1..1023).
- PAR_BITS, 195, generator degree (M*T = 13*15); fixed by the package constant.
- PAR_BYTES, 25, ceil(PAR_BITS/8); derived, not overridable.

Ports:
- clk_i      input   1   system clock, all logic on rising edge.
- rst_i      input   1   asynchronous active-high reset.
- start_i    input   1   one-cycle pulse: begin a new sector; clears the LFSR.
- data_i     input   8   data byte; bit 7 enters the LFSR first.
- data_vld_i input   1   data_i valid.
- data_rdy_o output  1   encoder accepts data_i this cycle.
- par_o      output  8   parity byte.
- par_vld_o  output  1   par_o valid.
- par_rdy_i  input   1   downstream accepts par_o.
- busy_o     output  1   high from an accepted start_i until the last parity byte is taken.
- done_o     output  1   one-cycle pulse after the final parity byte transfer.

Behaviour:
- Reset: state=IDLE, LFSR=0, counters=0. data_rdy_o=0, par_vld_o=0, par_o=0, busy_o=0, done_o=0. Reset mid-sector aborts; no parity is emitted.
- FSM IDLE -> ENC on start_i. ENC -> OUT after the DATA_BYTES-th data transfer. OUT -> IDLE after the PAR_BYTES-th parity transfer.
- IDLE:
  - data_rdy_o=0 and par_vld_o=0.
  - start_i clears the LFSR and byte count; the state is ENC from the next cycle.
- ENC:
  - data_rdy_o=1.
  - Each cycle with data_vld_i & data_rdy_o: 8 serial LFSR steps unrolled combinationally, MSB first.
    - Per step: fb = d ^ r[194]; r = (r<<1) ^ (fb ? G[194:0] : 0).
  - Byte counter increments per transfer.
- ENC, last byte: on the DATA_BYTES-th transfer, data_rdy_o drops the next cycle and the state becomes OUT.
- OUT, first byte: par_vld_o=1 in the first cycle after the last data transfer (1-cycle latency); the first par_o is r[194:187].
- OUT, shifting:
  - On par_vld_o & par_rdy_i, the remainder register shifts left by 8 and the parity counter increments.
  - par_o and par_vld_o hold stable while par_rdy_i=0.
- Last parity byte: byte 24 carries r[2:0] in bits [7:5]; bits [4:0]=0.
- Completion: on the 25th transfer, the state is IDLE next cycle, done_o pulses for 1 cycle and busy_o falls the same cycle.
- start_i while busy_o=1 is ignored (no restart, no error).
- data_vld_i while not ENC is ignored.
- start_i in the same cycle as the final parity transfer is ignored (the FSM is not yet in IDLE).
- Throughput: 1 byte/cycle in, 1 byte/cycle out, no bubbles under full handshake.

Optional Feature:
- Macro: BCHECC_ENC_PAR_INV_EN.
- Defined: every parity byte is XORed with 8'hFF before par_o, including the padding bits of byte 24. An erased all-0xFF page then reads back as a valid codeword; the read side must re-invert.
- Undefined: parity is output uninverted.
- The LFSR contents are identical in both builds.

Decomposition:
- Package bchecc_pkg holds:
  - BCH_M=13, BCH_T=15, BCH_PAR_BITS=195, BCH_PAR_BYTES=25.
  - Generator polynomial constant BCH_GEN_POLY[195:0], with the implicit x^195 term as bit 195.
  - The FSM state enumeration.
- Sub-module bchecc_enc_lfsr8: purely combinational next-remainder function (195-bit r, 8-bit d -> 195-bit r'), reusable by a future parallel re-encoder.
- FSM, counters and handshake stay in bchecc_encoder.

Test Plan:
- All-zero sector: start, 512 bytes of 0x00 with data_vld_i held high -> 25 parity bytes 0x00 (0xFF with BCHECC_ENC_PAR_INV_EN); done_o after 512+25+1 cycles from start.
- Single bit: byte 511 = 0x01, rest 0x00 -> parity equals G[194:0] packed MSB-first (par_o[0] = G[194:187]); check against the C golden model.
- Random sectors (100): parity matches the golden model; appending the parity gives codeword syndromes S1..S30 = 0 via the read-side gfmult path.
- Backpressure: random data_vld_i and par_rdy_i gaps, including par_rdy_i=0 for 10 cycles on byte 24 -> identical parity; par_o stable during stalls.
- Reset at byte 300 and again at parity byte 5 -> all outputs 0 next cycle. A new sector then encodes correctly, with no stale LFSR state.
- start_i pulsed mid-ENC and mid-OUT -> ignored; parity unchanged; busy_o stays high.
